// File: rtl/fir_l3_pkg.sv
// fir_l3_pkg: shared lane count, widths and lane-state types for the L=3 FIR datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fir_l3_pkg;

  localparam int L3_LANES      = 3;
  localparam int L3_DATA_IN_W  = 64;
  localparam int L3_DATA_OUT_W = 16;
  localparam int L3_FRAC_SHIFT = 31;

  typedef logic [1:0] lane_idx_t;

  typedef enum logic [1:0] {
    LANE0 = 2'd0,
    LANE1 = 2'd1,
    LANE2 = 2'd2
  } lane_state_t;

endpackage

// File: rtl/fir_l3_frame_fifo.sv
// fir_l3_frame_fifo: circular buffer of DEPTH frames, each WIDTH bits, with occupancy count.
// Latency: a push at edge N is visible on rdata after edge N when the buffer was empty.
// Backpressure: full/empty are registered-count based; push when full and pop when empty are ignored.
module fir_l3_frame_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Frame storage needs no reset: only slots covered by count are ever read out.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks push minus pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fir_l3_out_serializer.sv
// fir_l3_out_serializer: rescales 3-lane Q31 FIR frames to 16-bit words and streams them oldest-first.
// Latency: a frame pushed at edge N into an empty buffer presents its first sample after edge N.
// Backpressure: FRAME_DEPTH-frame buffer; in_ready = !full, out_data holds while out_valid && !out_ready.
// Build option: define FIR_L3_SER_SAT_EN for saturating narrowing and ovf_sticky; otherwise wrap.
module fir_l3_out_serializer
  import fir_l3_pkg::*;
#(
  parameter int DATA_IN_WIDTH  = L3_DATA_IN_W,
  parameter int DATA_OUT_WIDTH = L3_DATA_OUT_W,
  parameter int FRAC_SHIFT     = L3_FRAC_SHIFT,
  parameter int FRAME_DEPTH    = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_IN_WIDTH-1:0]  in_1,
  input  logic [DATA_IN_WIDTH-1:0]  in_2,
  input  logic [DATA_IN_WIDTH-1:0]  in_3,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_OUT_WIDTH-1:0] out_data,
  output logic                      ovf_sticky
);

  localparam int IW = DATA_IN_WIDTH;
  localparam int OW = DATA_OUT_WIDTH;
  localparam int FW = L3_LANES * OW;

  // Half an output LSB in the input domain, for round-half-toward-+inf.
  localparam logic signed [IW:0] HALF =
    {{(IW + 1 - FRAC_SHIFT){1'b0}}, 1'b1, {(FRAC_SHIFT - 1){1'b0}}};

  logic [L3_LANES-1:0][IW-1:0] lane_in;
  logic [L3_LANES-1:0][IW:0]   sum;
  logic [L3_LANES-1:0][IW:0]   s;
  logic [FW-1:0]               wframe;
  logic [FW-1:0]               rframe;
  logic [$clog2(FRAME_DEPTH):0] fifo_count;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        push;
  logic                        pop;
  logic                        fire;
  lane_state_t                 state;
  lane_state_t                 state_nx;
  logic                        unused_bits;

  assign lane_in[0] = in_1;
  assign lane_in[1] = in_2;
  assign lane_in[2] = in_3;

  assign in_ready  = !fifo_full;
  assign out_valid = !fifo_empty;
  assign push      = in_valid && in_ready;
  assign fire      = out_valid && out_ready;

  // Count is consumed only through full/empty; scaled upper bits only matter when saturating.
  assign unused_bits = ^{fifo_count, s};

`ifdef FIR_L3_SER_SAT_EN
  localparam logic signed [IW:0] SAT_MAX = {{(IW - OW + 2){1'b0}}, {(OW - 1){1'b1}}};
  localparam logic signed [IW:0] SAT_MIN = {{(IW - OW + 2){1'b1}}, {(OW - 1){1'b0}}};
  logic [L3_LANES-1:0] clamp;

  // Round, shift, then clamp each lane to the signed output range.
  always_comb begin
    wframe = '0;
    clamp  = '0;
    sum    = '0;
    s      = '0;
    for (int i = 0; i < L3_LANES; i++) begin
      sum[i] = $signed({lane_in[i][IW-1], lane_in[i]}) + HALF;
      s[i]   = $signed(sum[i]) >>> FRAC_SHIFT;
      if ($signed(s[i]) > SAT_MAX) begin
        wframe[i*OW +: OW] = SAT_MAX[OW-1:0];
        clamp[i]           = 1'b1;
      end else if ($signed(s[i]) < SAT_MIN) begin
        wframe[i*OW +: OW] = SAT_MIN[OW-1:0];
        clamp[i]           = 1'b1;
      end else begin
        wframe[i*OW +: OW] = s[i][OW-1:0];
      end
    end
  end

  // Remember any clamped lane of an accepted frame until reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              ovf_sticky <= 1'b0;
    else if (push && |clamp)   ovf_sticky <= 1'b1;
  end
`else
  // Round, shift, then keep the low output bits (two's-complement wrap).
  always_comb begin
    wframe = '0;
    sum    = '0;
    s      = '0;
    for (int i = 0; i < L3_LANES; i++) begin
      sum[i]             = $signed({lane_in[i][IW-1], lane_in[i]}) + HALF;
      s[i]               = $signed(sum[i]) >>> FRAC_SHIFT;
      wframe[i*OW +: OW] = s[i][OW-1:0];
    end
  end

  assign ovf_sticky = 1'b0;
`endif

  fir_l3_frame_fifo #(
    .WIDTH (FW),
    .DEPTH (FRAME_DEPTH)
  ) u_frame_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wdata   (wframe),
    .pop     (pop),
    .rdata   (rframe),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Lane counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= LANE0;
    else          state <= state_nx;
  end

  // Select the current lane of the head frame; advance on transfer, pop the frame after lane 2.
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    out_data = '0;
    case (state)
      LANE0: begin
        out_data = rframe[0*OW +: OW];
        if (fire) state_nx = LANE1;
      end
      LANE1: begin
        out_data = rframe[1*OW +: OW];
        if (fire) state_nx = LANE2;
      end
      LANE2: begin
        out_data = rframe[2*OW +: OW];
        if (fire) begin
          state_nx = LANE0;
          pop      = 1'b1;
        end
      end
      default: state_nx = LANE0;
    endcase
    if (!out_valid) out_data = '0;
  end

endmodule

// File: tb/tb_fir_l3_out_serializer.sv
// tb_fir_l3_out_serializer: directed and model-checked stimulus for the 3-lane output serializer.
// Latency: inputs driven and outputs sampled on the falling edge, one clock per step.
// Backpressure: exercised through out_ready hold-off, full buffer and same-cycle push/pop.
module tb_fir_l3_out_serializer;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               in_valid;
  logic               in_ready;
  logic [63:0]        in_1;
  logic [63:0]        in_2;
  logic [63:0]        in_3;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_data;
  logic               ovf_sticky;

  int n_cmp = 0;
  int n_bad = 0;

  int                 q[$];
  int                 pushed;
  int                 nfr;
  int                 sv[3];
  logic [30:0]        fv[3];
  logic signed [63:0] xv[3];

  fir_l3_out_serializer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_1       (in_1),
    .in_2       (in_2),
    .in_3       (in_3),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .ovf_sticky (ovf_sticky)
  );

  always #5 clk = ~clk;

  function automatic logic signed [63:0] q31(input int v);
    logic signed [63:0] t;
    t = 64'(v);
    return t <<< 31;
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic expect_data(input string tag, input int exp);
    check({tag, "_vld"}, out_valid, 1);
    check(tag, out_data, exp);
    @(negedge clk);
  endtask

  task automatic push_frame(input logic signed [63:0] a, input logic signed [63:0] b,
                            input logic signed [63:0] c);
    in_valid = 1'b1;
    in_1 = a;
    in_2 = b;
    in_3 = c;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_1 = '0;
    in_2 = '0;
    in_3 = '0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_data", out_data, 0);
    check("rst_ovf", ovf_sticky, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic frame, sink always ready.
    out_ready = 1'b1;
    push_frame(q31(1), q31(2), q31(3));
    expect_data("basic0", 1);
    expect_data("basic1", 2);
    expect_data("basic2", 3);
    check("basic_empty", out_valid, 0);

    // Rounding: 1.5 -> 2, -1.5 -> -1, just under 0.5 -> 0.
    push_frame(64'sd3 <<< 30, -(64'sd3 <<< 30), (64'sd1 <<< 30) - 64'sd1);
    expect_data("round0", 2);
    expect_data("round1", -1);
    expect_data("round2", 0);

    // Out-of-range samples.
    push_frame(q31(40000), q31(-40000), q31(0));
`ifdef FIR_L3_SER_SAT_EN
    check("sat_ovf", ovf_sticky, 1);
    expect_data("sat0", 32767);
    expect_data("sat1", -32768);
    expect_data("sat2", 0);
`else
    check("wrap_ovf", ovf_sticky, 0);
    expect_data("wrap0", -25536);
    expect_data("wrap1", 25536);
    expect_data("wrap2", 0);
`endif

    // Backpressure: fill four frames while the sink is stalled.
    out_ready = 1'b0;
    for (int f = 0; f < 4; f++) begin
      check("bp_in_ready_fill", in_ready, 1);
      push_frame(q31(10 + 3*f), q31(11 + 3*f), q31(12 + 3*f));
    end
    check("bp_full", in_ready, 0);
    check("bp_hold_data", out_data, 10);
    in_valid = 1'b1;
    in_1 = q31(99);
    in_2 = q31(99);
    in_3 = q31(99);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_hold_data2", out_data, 10);
    check("bp_still_full", in_ready, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      check("bp_in_ready", in_ready, (i >= 3) ? 1 : 0);
      expect_data("bp_data", 10 + i);
    end
    check("bp_drained", out_valid, 0);

    // Same-cycle push and final-lane pop.
    out_ready = 1'b0;
    for (int f = 0; f < 4; f++) push_frame(q31(30 + 3*f), q31(31 + 3*f), q31(32 + 3*f));
    out_ready = 1'b1;
    expect_data("pp_a", 30);
    expect_data("pp_b", 31);
    check("pp_full_at_lane2", in_ready, 0);
    in_valid = 1'b1;
    in_1 = q31(77);
    in_2 = q31(77);
    in_3 = q31(77);
    expect_data("pp_c", 32);
    in_valid = 1'b0;
    check("pp_reopen", in_ready, 1);
    expect_data("pp_d", 33);
    expect_data("pp_e", 34);
    check("pp_ready_lane2", in_ready, 1);
    in_valid = 1'b1;
    in_1 = q31(42);
    in_2 = q31(43);
    in_3 = q31(44);
    expect_data("pp_f", 35);
    in_valid = 1'b0;
    check("pp_count_same", in_ready, 1);
    for (int v = 36; v <= 44; v++) expect_data("pp_tail", v);
    check("pp_drained", out_valid, 0);

    // Random traffic against a sample queue model.
    pushed = 0;
    for (int cyc = 0; cyc < 3000 && (pushed < 100 || q.size() != 0); cyc++) begin
      in_valid  = (pushed < 100) && ($urandom_range(0, 2) == 0);
      out_ready = (pushed >= 100) || ($urandom_range(0, 4) != 0);
      for (int l = 0; l < 3; l++) begin
        sv[l] = int'($urandom_range(0, 65534)) - 32768;
        fv[l] = 31'($urandom);
        xv[l] = q31(sv[l]) + {33'd0, fv[l]};
      end
      in_1 = xv[0];
      in_2 = xv[1];
      in_3 = xv[2];
      nfr = (q.size() + 2) / 3;
      check("rnd_valid", out_valid, (q.size() != 0) ? 1 : 0);
      check("rnd_in_ready", in_ready, (nfr < 4) ? 1 : 0);
      if (out_valid && out_ready && q.size() != 0) begin
        check("rnd_data", out_data, q[0]);
        void'(q.pop_front());
      end
      if (in_valid && in_ready) begin
        for (int l = 0; l < 3; l++) q.push_back(sv[l] + int'(fv[l][30]));
        pushed++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("rnd_all_pushed", pushed, 100);
    check("rnd_all_drained", q.size(), 0);

    // Reset in the middle of a frame.
    out_ready = 1'b1;
    push_frame(q31(4), q31(5), q31(6));
    expect_data("mid0", 4);
    expect_data("mid1", 5);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_ovf", ovf_sticky, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_empty", out_valid, 0);
    push_frame(q31(7), q31(8), q31(9));
    expect_data("post0", 7);
    expect_data("post1", 8);
    expect_data("post2", 9);
    check("post_empty", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
